// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the KGP-RISC fetch/PC sequencer: branch_op encodings,
// sequencer states and the instruction size.
package pc_sequencer_pkg;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_JR   = 3'd1,
        BR_JUMP = 3'd2,
        BR_RSV3 = 3'd3,
        BR_Z    = 3'd4,
        BR_NZ   = 3'd5,
        BR_NEG  = 3'd6,
        BR_RSV7 = 3'd7
    } branch_op_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } seq_state_e;

    // Instruction targets are word aligned; low address bits are dropped silently.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_calc.sv
// Combinational next-PC resolution for one committed instruction: chooses between
// the sequential, jump-register and pc-relative targets and flags taken/reserved ops.
module next_pc_calc
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [2:0]  branch_op_i,
    input  logic [31:0] rs_val_i,
    input  logic [31:0] br_offset_i,
    output logic [31:0] next_pc_o,
    output logic        taken_o,
    output logic        illegal_o
);

    logic [31:0] seq_pc_s;
    logic [31:0] rel_pc_s;
    logic [31:0] raw_pc_s;

    assign seq_pc_s = pc_i + INSTR_BYTES;
    assign rel_pc_s = seq_pc_s + br_offset_i;

    // Select the raw target and classify the branch outcome
    always_comb begin
        raw_pc_s  = seq_pc_s;
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (branch_op_e'(branch_op_i))
            BR_NONE: raw_pc_s = seq_pc_s;
            BR_JR: begin
                raw_pc_s = rs_val_i;
                taken_o  = 1'b1;
            end
            BR_JUMP: begin
                raw_pc_s = rel_pc_s;
                taken_o  = 1'b1;
            end
            BR_Z: begin
                if (rs_val_i == 32'd0) begin
                    raw_pc_s = rel_pc_s;
                    taken_o  = 1'b1;
                end else begin
                    raw_pc_s = seq_pc_s;
                end
            end
            BR_NZ: begin
                if (rs_val_i != 32'd0) begin
                    raw_pc_s = rel_pc_s;
                    taken_o  = 1'b1;
                end else begin
                    raw_pc_s = seq_pc_s;
                end
            end
            BR_NEG: begin
                if (rs_val_i[31]) begin
                    raw_pc_s = rel_pc_s;
                    taken_o  = 1'b1;
                end else begin
                    raw_pc_s = seq_pc_s;
                end
            end
            default: begin
                raw_pc_s  = seq_pc_s;
                illegal_o = 1'b1;
            end
        endcase
    end

    assign next_pc_o = word_align(raw_pc_s);

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle FETCH/EXEC/HALT program-counter sequencer for the KGP-RISC core.
// Optional `PC_BRANCH_COUNT_EN adds a taken_count output counting taken pulses.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_W     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [PC_W-1:0] imem_data,
    output logic [PC_W-1:0] instr,
    output logic            instr_valid,
    input  logic            stall,
    input  logic [2:0]      branch_op,
    input  logic [PC_W-1:0] rs_val,
    input  logic [PC_W-1:0] br_offset,
    input  logic            halt,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] link_addr,
    output logic            taken,
    output logic            illegal_op,
`ifdef PC_BRANCH_COUNT_EN
    output logic [31:0]     taken_count,
`endif
    output logic            halted
);

    seq_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        taken_q, taken_d;
    logic        illegal_q, illegal_d;

    logic [31:0] npc_s;
    logic        npc_taken_s;
    logic        npc_illegal_s;

    next_pc_calc u_next_pc_calc (
        .pc_i        (pc_q),
        .branch_op_i (branch_op),
        .rs_val_i    (rs_val),
        .br_offset_i (br_offset),
        .next_pc_o   (npc_s),
        .taken_o     (npc_taken_s),
        .illegal_o   (npc_illegal_s)
    );

    // Next-state logic: fetch handshake, execute/stall and PC commit
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        taken_d   = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_data;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (stall) begin
                    state_d = ST_EXEC;
                end else begin
                    pc_d      = npc_s;
                    taken_d   = npc_taken_s;
                    illegal_d = npc_illegal_s;
                    state_d   = halt ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // State, PC, instruction and pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef PC_BRANCH_COUNT_EN
    logic [31:0] count_q;

    // Taken counter advances on the same edge that raises the taken pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_q + {31'd0, taken_d};
        end
    end

    assign taken_count = count_q;
`endif

    // Request is suppressed while reset is held even though the state is FETCH.
    assign imem_req    = (state_q == ST_FETCH) & ~rst;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == ST_EXEC);
    assign halted      = (state_q == ST_HALT);
    assign pc          = pc_q;
    assign link_addr   = pc_q + INSTR_BYTES;
    assign taken       = taken_q;
    assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// instruction streams checked against a behavioural next-PC model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic [2:0]  branch_op;
    logic [31:0] rs_val;
    logic [31:0] br_offset;
    logic        halt;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        taken;
    logic        illegal_op;
    logic        halted;
`ifdef PC_BRANCH_COUNT_EN
    logic [31:0] taken_count;
`endif

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] o_faddr, o_instr, o_pc, o_link, o_next;
    logic        o_tk, o_il, o_halted, o_req_after, o_valid;
    bit          o_stable, o_held;
    int          o_cycles;
    logic [31:0] exp_pc;
    int          exp_count;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .PC_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .stall       (stall),
        .branch_op   (branch_op),
        .rs_val      (rs_val),
        .br_offset   (br_offset),
        .halt        (halt),
        .pc          (pc),
        .link_addr   (link_addr),
        .taken       (taken),
        .illegal_op  (illegal_op),
`ifdef PC_BRANCH_COUNT_EN
        .taken_count (taken_count),
`endif
        .halted      (halted)
    );

    // Behavioural next-PC rule: taken ops go to their target, everything else falls through.
    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [2:0] op,
                                             input logic [31:0] rs, input logic [31:0] off,
                                             output logic tk, output logic il);
        logic [31:0] dest;
        il = (op == 3'd3) || (op == 3'd7);
        tk = (op == 3'd1) || (op == 3'd2) || (op == 3'd4 && rs == 32'd0) ||
             (op == 3'd5 && rs != 32'd0) || (op == 3'd6 && rs[31]);
        dest = (op == 3'd1) ? rs : p + 32'd4 + off;
        if (!tk) dest = p + 32'd4;
        return dest & 32'hFFFF_FFFC;
    endfunction

    // Drives one full instruction starting at a negedge in the first FETCH cycle;
    // ends at the negedge of the first cycle after commit. Records observations only.
    task automatic do_instr(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] off,
                            input logic [31:0] dat, input logic hlt, input int ack_dly, input int stl);
        int c;
        c = 0;
        o_stable = 1'b1;
        o_held = 1'b1;
        o_faddr = imem_addr;
        if (imem_req !== 1'b1) o_stable = 1'b0;
        imem_ack = 1'b0;
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk); c++;
            if (imem_addr !== o_faddr || imem_req !== 1'b1 || instr_valid !== 1'b0) o_stable = 1'b0;
        end
        imem_ack = 1'b1;
        imem_data = dat;
        @(negedge clk); c++;
        imem_ack = 1'($urandom);
        imem_data = $urandom;
        o_instr = instr; o_valid = instr_valid; o_pc = pc; o_link = link_addr;
        stall = (stl > 0); halt = hlt; branch_op = op; rs_val = rs; br_offset = off;
        for (int i = 0; i < stl; i++) begin
            @(negedge clk); c++;
            if (pc !== o_pc || instr !== o_instr || instr_valid !== 1'b1) o_held = 1'b0;
        end
        stall = 1'b0;
        @(negedge clk); c++;
        o_tk = taken; o_il = illegal_op; o_next = pc; o_halted = halted; o_req_after = imem_req;
        o_cycles = c;
        imem_ack = 1'b0; halt = 1'b0;
        branch_op = 3'($urandom); rs_val = $urandom; br_offset = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 1'b0; imem_data = 32'd0; stall = 1'b0;
        branch_op = 3'd0; rs_val = 32'd0; br_offset = 32'd0; halt = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (imem_req !== 1'b0) $display("FAIL rst_req got %b want 0", imem_req); else n_pass++;
        n_total++; if (pc !== 32'h0) $display("FAIL rst_pc got %h want 00000000", pc); else n_pass++;
        n_total++; if (instr !== 32'h0) $display("FAIL rst_instr got %h want 00000000", instr); else n_pass++;
        n_total++; if ({instr_valid, taken, illegal_op, halted} !== 4'b0000)
            $display("FAIL rst_flags got %b want 0000", {instr_valid, taken, illegal_op, halted}); else n_pass++;
        n_total++; if (link_addr !== 32'h4) $display("FAIL rst_link got %h want 00000004", link_addr); else n_pass++;
`ifdef PC_BRANCH_COUNT_EN
        n_total++; if (taken_count !== 32'd0) $display("FAIL rst_count got %0d want 0", taken_count); else n_pass++;
`endif
        rst = 1'b0;
        #1;
        n_total++; if (imem_req !== 1'b1) $display("FAIL first_fetch_req got %b want 1", imem_req); else n_pass++;
        exp_pc = 32'h0;
        exp_count = 0;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            do_instr(3'd0, $urandom, $urandom, $urandom, 1'b0, 0, 0);
            n_total++; if (o_faddr !== exp_pc) $display("FAIL seq_addr got %h want %h", o_faddr, exp_pc); else n_pass++;
            n_total++; if (o_cycles != 2) $display("FAIL seq_cycles got %0d want 2", o_cycles); else n_pass++;
            n_total++; if (o_tk !== 1'b0) $display("FAIL seq_taken got %b want 0", o_tk); else n_pass++;
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_jump();
        do_instr(3'd2, $urandom, 32'h20, $urandom, 1'b0, 1, 0);
        exp_count++;
        n_total++; if (o_faddr !== 32'h10) $display("FAIL jump_pc got %h want 00000010", o_faddr); else n_pass++;
        n_total++; if (o_link !== 32'h14) $display("FAIL jump_link got %h want 00000014", o_link); else n_pass++;
        n_total++; if (o_next !== 32'h34) $display("FAIL jump_next got %h want 00000034", o_next); else n_pass++;
        n_total++; if (o_tk !== 1'b1) $display("FAIL jump_taken got %b want 1", o_tk); else n_pass++;
        @(negedge clk);
        n_total++; if (taken !== 1'b0) $display("FAIL jump_pulse_width got %b want 0", taken); else n_pass++;
        n_total++; if (imem_addr !== 32'h34) $display("FAIL jump_addr_hold got %h want 00000034", imem_addr); else n_pass++;
        exp_pc = 32'h34;
    endtask

    task automatic test_cond();
        logic [2:0]  ops [6]  = '{3'd4, 3'd4, 3'd6, 3'd5, 3'd5, 3'd6};
        logic [31:0] rss [6]  = '{32'h0, 32'h5, 32'h8000_0000, 32'h0, 32'h7, 32'h7FFF_FFFF};
        logic [31:0] offs [6] = '{32'h100, 32'h100, 32'hFFFF_FFF8, 32'h40, 32'h3, 32'h40};
        logic [31:0] nxt [6]  = '{32'h138, 32'h13C, 32'h138, 32'h13C, 32'h140, 32'h144};
        logic        tks [6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            do_instr(ops[i], rss[i], offs[i], $urandom, 1'b0, i % 2, 0);
            if (tks[i]) exp_count++;
            n_total++; if (o_next !== nxt[i]) $display("FAIL cond%0d_next got %h want %h", i, o_next, nxt[i]); else n_pass++;
            n_total++; if (o_tk !== tks[i]) $display("FAIL cond%0d_taken got %b want %b", i, o_tk, tks[i]); else n_pass++;
        end
        exp_pc = 32'h144;
    endtask

    task automatic test_jr_illegal();
        logic [2:0]  ops [5] = '{3'd1, 3'd7, 3'd3, 3'd1, 3'd0};
        logic [31:0] rss [5] = '{32'h103, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0};
        logic [31:0] nxt [5] = '{32'h100, 32'h104, 32'h108, 32'hFFFF_FFFC, 32'h0};
        logic        tks [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        ils [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            do_instr(ops[i], rss[i], 32'h10, $urandom, 1'b0, 0, 0);
            if (tks[i]) exp_count++;
            n_total++; if (o_next !== nxt[i]) $display("FAIL jri%0d_next got %h want %h", i, o_next, nxt[i]); else n_pass++;
            n_total++; if ({o_tk, o_il} !== {tks[i], ils[i]})
                $display("FAIL jri%0d_flags got %b%b want %b%b", i, o_tk, o_il, tks[i], ils[i]); else n_pass++;
        end
        exp_pc = 32'h0;
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] rs, off, dat, e;
        logic        etk, eil;
        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(0, 7));
            rs  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            off = $urandom;
            dat = $urandom;
            e = ref_next(exp_pc, op, rs, off, etk, eil);
            do_instr(op, rs, off, dat, 1'b0, $urandom_range(0, 2), $urandom_range(0, 2));
            if (etk) exp_count++;
            n_total++; if (o_faddr !== exp_pc || !o_stable)
                $display("FAIL rnd%0d_fetch got %h stable=%0d want %h", i, o_faddr, o_stable, exp_pc); else n_pass++;
            n_total++; if (o_instr !== dat || o_valid !== 1'b1)
                $display("FAIL rnd%0d_instr got %h v=%b want %h v=1", i, o_instr, o_valid, dat); else n_pass++;
            n_total++; if (o_link !== exp_pc + 32'd4) $display("FAIL rnd%0d_link got %h want %h", i, o_link, exp_pc + 32'd4); else n_pass++;
            n_total++; if (!o_held) $display("FAIL rnd%0d_stall_hold got 0 want 1", i); else n_pass++;
            n_total++; if (o_next !== e) $display("FAIL rnd%0d_next got %h want %h", i, o_next, e); else n_pass++;
            n_total++; if ({o_tk, o_il} !== {etk, eil})
                $display("FAIL rnd%0d_flags got %b%b want %b%b", i, o_tk, o_il, etk, eil); else n_pass++;
            exp_pc = e;
        end
`ifdef PC_BRANCH_COUNT_EN
        n_total++; if (taken_count !== 32'(exp_count)) $display("FAIL taken_count got %0d want %0d", taken_count, exp_count); else n_pass++;
`endif
    endtask

    task automatic test_stall_halt();
        logic [31:0] hold_pc;
        do_instr(3'd0, 32'h0, 32'h0, $urandom, 1'b1, 0, 3);
        n_total++; if (!o_held) $display("FAIL halt_stall_hold got 0 want 1"); else n_pass++;
        n_total++; if (o_cycles != 5) $display("FAIL halt_cycles got %0d want 5", o_cycles); else n_pass++;
        n_total++; if (o_next !== exp_pc + 32'd4) $display("FAIL halt_next got %h want %h", o_next, exp_pc + 32'd4); else n_pass++;
        n_total++; if ({o_halted, o_req_after} !== 2'b10)
            $display("FAIL halt_enter got halted=%b req=%b want 1/0", o_halted, o_req_after); else n_pass++;
        hold_pc = pc;
        imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        imem_ack = 1'b0;
        n_total++; if ({halted, imem_req, instr_valid} !== 3'b100 || pc !== hold_pc)
            $display("FAIL halt_stay got h/r/v=%b%b%b pc=%h want 100 pc=%h", halted, imem_req, instr_valid, pc, hold_pc); else n_pass++;
    endtask

    task automatic test_reset_midfetch();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_instr(3'd1, 32'h40, 32'h0, $urandom, 1'b0, 0, 0);
        n_total++; if (o_next !== 32'h40) $display("FAIL midrst_setup got %h want 00000040", o_next); else n_pass++;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_total++; if (imem_req !== 1'b0 || pc !== 32'h0)
            $display("FAIL midrst_async got req=%b pc=%h want 0/00000000", imem_req, pc); else n_pass++;
`ifdef PC_BRANCH_COUNT_EN
        n_total++; if (taken_count !== 32'd0) $display("FAIL midrst_count got %0d want 0", taken_count); else n_pass++;
`endif
        imem_ack = 1'b1;
        imem_data = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        rst = 1'b0;
        #1;
        n_total++; if (instr !== 32'h0 || instr_valid !== 1'b0)
            $display("FAIL midrst_late_ack got instr=%h v=%b want 00000000/0", instr, instr_valid); else n_pass++;
        @(negedge clk);
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0)
            $display("FAIL midrst_refetch got req=%b addr=%h v=%b want 1/00000000/0", imem_req, imem_addr, instr_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump();
        test_cond();
        test_jr_illegal();
        test_random();
        test_stall_halt();
        test_reset_midfetch();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
